// File: rtl/hamming_decoder.sv
// ---------------------------------------------------------------------------
// hamming_decoder
//   Serial Hamming(7,4) decoder with a trailing marker bit. Each codeword is
//   eight bits, c0 first, c7 (marker, expected 1) last. A single-bit error in
//   c0..c6 is corrected, and the four data bits d3..d0 are emitted serially
//   on the four cycles after the c7 capture edge.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   in         in   serial codeword bit, sampled when in_esig=1
//   in_esig    in   input-valid strobe, 8 consecutive cycles per codeword
//   out        out  serial decoded data bit (0 when out_esig=0)
//   out_esig   out  output-valid strobe, 4 cycles per decoded codeword
//   err_corr   out  single-bit error corrected in the current word
//   err_marker out  marker bit c7 was received as 0
//   err_frame  out  one-cycle pulse when a partial codeword is aborted
//   corr_count out  saturating count of corrected words since reset
// ---------------------------------------------------------------------------
module hamming_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic       in,
    input  logic       in_esig,
    output logic       out,
    output logic       out_esig,
    output logic       err_corr,
    output logic       err_marker,
    output logic       err_frame,
    output logic [7:0] corr_count
);

    logic [2:0] rx_cnt;     // index of the next codeword bit to capture
    logic [6:0] rx_sr;      // rx_sr[i] holds c_i for i = 0..6
    logic [2:0] tx_shift;   // remaining data bits still to be emitted
    logic [1:0] tx_cnt;     // number of data bits still to be emitted

    // Decode path: c7 is taken straight from the input on the capture edge,
    // so the whole word is decoded combinationally in that same cycle.
    logic [7:0] word;
    logic [2:0] syndrome;
    logic [6:0] fixed;
    logic [3:0] data;
    logic       load;

    assign word = {in, rx_sr};
    assign load = in_esig && (rx_cnt == 3'd7);

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        syndrome[0] = word[0] ^ word[3] ^ word[4] ^ word[5];
        syndrome[1] = word[1] ^ word[4] ^ word[5] ^ word[6];
        syndrome[2] = word[2] ^ word[3] ^ word[4] ^ word[6];
        fixed       = word[6:0];
        case (syndrome)
            3'b001:  fixed[0] = ~word[0];
            3'b010:  fixed[1] = ~word[1];
            3'b100:  fixed[2] = ~word[2];
            3'b101:  fixed[3] = ~word[3];
            3'b111:  fixed[4] = ~word[4];
            3'b011:  fixed[5] = ~word[5];
            3'b110:  fixed[6] = ~word[6];
            default: fixed    = word[6:0];
        endcase
        data = {fixed[6], fixed[5], fixed[4], fixed[3]};  // d3..d0
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // The shift register is reset along with everything else so that
            // a burst after reset never decodes stale bits.
            rx_cnt     <= 3'd0;
            rx_sr      <= 7'd0;
            tx_shift   <= 3'd0;
            tx_cnt     <= 2'd0;
            out        <= 1'b0;
            out_esig   <= 1'b0;
            err_corr   <= 1'b0;
            err_marker <= 1'b0;
            err_frame  <= 1'b0;
            corr_count <= 8'd0;
        end else begin
            // Receive side
            err_frame <= 1'b0;
            if (in_esig) begin
                if (rx_cnt != 3'd7)
                    rx_sr[rx_cnt] <= in;
                rx_cnt <= rx_cnt + 3'd1;   // wraps 7 -> 0 after c7
            end else if (rx_cnt != 3'd0) begin
                // Strobe dropped mid-word: discard and flag the framing error.
                rx_cnt    <= 3'd0;
                err_frame <= 1'b1;
            end

            // Transmit side: a new load always wins; since a word takes eight
            // cycles to arrive, the previous burst has finished by then.
            if (load) begin
                out        <= data[3];
                tx_shift   <= data[2:0];
                tx_cnt     <= 2'd3;
                out_esig   <= 1'b1;
                err_corr   <= (syndrome != 3'b000);
                err_marker <= ~in;
                if (syndrome != 3'b000 && corr_count != 8'hFF)
                    corr_count <= corr_count + 8'd1;
            end else if (tx_cnt != 2'd0) begin
                out      <= tx_shift[2];
                tx_shift <= {tx_shift[1:0], 1'b0};
                tx_cnt   <= tx_cnt - 2'd1;
            end else begin
                out        <= 1'b0;
                out_esig   <= 1'b0;
                err_corr   <= 1'b0;
                err_marker <= 1'b0;
            end
        end
    end

endmodule

// File: doc/hamming_decoder.md
HAMMING_DECODER -- requirements
Module: hamming_decoder

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock; sole clock domain.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port in  input  1  serial codeword bit, sampled only when in_esig=1.
REQ-004 SHALL have port in_esig  input  1  input-valid strobe; high for 8 consecutive cycles per codeword.
REQ-005 SHALL have port out  output  1  serial decoded data bit.
REQ-006 SHALL have port out_esig  output  1  output-valid strobe; high for exactly 4 consecutive cycles per decoded codeword.
REQ-007 SHALL have port err_corr  output  1  single-bit error corrected in current word; valid while out_esig=1.
REQ-008 SHALL have port err_marker  output  1  marker bit c7 received as 0; valid while out_esig=1.
REQ-009 SHALL have port err_frame  output  1  one-cycle pulse when a partial codeword is aborted.
REQ-010 SHALL have port corr_count  output  8  saturating count of corrected words since reset.

Function
REQ-011 Codeword bits SHALL arrive serially in order c0 first, c7 last; data bits d3..d0, with d3 the first data bit the encoder accepted.
REQ-012 Code definition: c0=d2^d1^d0, c1=d3^d2^d1, c2=d3^d1^d0, c3=d0, c4=d1, c5=d2, c6=d3, c7=1.
REQ-013 Syndrome SHALL be s0=c0^c3^c4^c5, s1=c1^c4^c5^c6, s2=c2^c3^c4^c6; syndrome {s2,s1,s0}.
REQ-014 Error position map: 001->c0, 010->c1, 100->c2, 101->c3, 111->c4, 011->c5, 110->c6; 000 = no error.
REQ-015 Nonzero syndrome SHALL invert the mapped bit before output and set err_corr=1; errors in c0-c2 leave data unchanged but still set err_corr.
REQ-016 err_marker SHALL equal NOT c7 and SHALL NOT affect syndrome or data.
REQ-017 Receive counter (0..7) SHALL increment on each cycle with in_esig=1 and wrap to 0 after c7 is captured.
REQ-018 On the edge capturing c7, decoded data and flags SHALL be loaded into an output holding register in the same edge (single-cycle decode).
REQ-019 Latency: out_esig SHALL assert in the cycle after the c7 capture edge; out SHALL carry d3, d2, d1, d0 on the 4 successive cycles.
REQ-020 err_corr and err_marker SHALL be held constant for the 4 out_esig cycles and SHALL be 0 whenever out_esig=0.
REQ-021 out SHALL be 0 whenever out_esig=0.
REQ-022 Reception SHALL continue during output; a new codeword may start the cycle after c7 (back-to-back), and its output SHALL follow without gaps beyond protocol spacing; no overrun is possible since 4 < 8.
REQ-023 in_esig falling to 0 with receive counter nonzero SHALL discard the partial word, clear the counter, and pulse err_frame for one cycle; no output generated.
REQ-024 in_esig=0 with counter 0 SHALL be idle; no err_frame.
REQ-025 corr_count SHALL increment by 1 when a word with err_corr=1 is loaded, saturating at 255.

Reset
REQ-026 reset=1 SHALL on the next edge clear receive counter, shift register, holding register, corr_count; out, out_esig, err_corr, err_marker, err_frame SHALL be 0.
REQ-027 reset mid-reception or mid-output SHALL abort all activity without err_frame; the next in_esig burst starts a new codeword at c0.
REQ-028 reset SHALL take priority over all simultaneous events.

Verification
REQ-029 Clean word: serial 0,0,1,1,1,0,1,1 (data 1011) -> out 1,0,1,1 on 4 cycles after c7, err_corr=0, err_marker=0.
REQ-030 Data error: serial 0,0,1,1,0,0,1,1 (c4 flipped, syndrome 111) -> out 1,0,1,1, err_corr=1, corr_count increments to 1.
REQ-031 Parity error: serial 1,0,1,1,1,0,1,1 (c0 flipped) -> out 1,0,1,1, err_corr=1; marker error: last bit 0 -> out 1,0,1,1, err_marker=1, err_corr=0.
REQ-032 Abort: in_esig high for 5 cycles then low -> err_frame one-cycle pulse, no out_esig; following full word decodes correctly.
REQ-033 Back-to-back: two clean words 1011 then 0000 (serial all zeros except c7=1) with no gap -> two 4-cycle out_esig bursts, outputs 1011 then 0000.
REQ-034 Reset during output burst -> out_esig drops to 0 next edge, corr_count=0, no err_frame.
